prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 38 +++
 rtl/prog_loader_uart_rx_byte.sv | 130 +++++++++++++
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and timing helpers for the program loader.
//   frame_state_e : frame parser states
//   rx_state_e    : UART byte engine states
//   SYNC_BYTE     : frame start marker
//   calc_div      : clock cycles per UART bit
//   calc_timeout  : inter-byte timeout in clock cycles
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Clock cycles per bit period (integer division).
    function automatic int unsigned calc_div(input int unsigned freq,
                                             input int unsigned baud);
        return freq / baud;
    endfunction

    // Inter-byte timeout expressed in clock cycles.
    function automatic int unsigned calc_timeout(input int unsigned freq,
                                                 input int unsigned baud,
                                                 input int unsigned bits);
        return bits * calc_div(freq, baud);
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// UART 8N1 byte receiver.
//   clk, rst_n  : clock, async active-low reset
//   rx_i        : raw UART line (idle high)
//   rx_valid_o  : one-cycle strobe, rx_data_o holds a byte with a good stop bit
//   rx_data_o   : last received byte
//   rx_ferr_o   : one-cycle strobe, stop bit sampled low (byte dropped)
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int unsigned DIV = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_ferr_o
);

    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             fall;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s2_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: start bit checked at half period, then one sample per DIV.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rx_s2_q) begin
                        // Line back high at mid start bit: glitch.
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d  = '0;
                    data_d = {rx_s2_q, data_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = data_q;
    assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a framed bytecode program over UART and writes it
// into the stack machine's code memory, starting the machine on a good frame.
//   clk, rst    : clock, async active-low reset
//   uart_rxp    : UART RX line (idle high)
//   code_we     : one-cycle write strobe per payload byte
//   code_addr   : payload byte index within the frame
//   code_wdata  : payload byte
//   vm_start    : one-cycle pulse after a frame with a matching checksum
//   busy        : frame in progress
//   err         : sticky error, cleared on the next accepted SYNC
//   prog_len    : payload length of the last good frame
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned FREQ         = 27_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CODE_DEPTH   = 16,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxp,
    output logic                          code_we,
    output logic [$clog2(CODE_DEPTH)-1:0] code_addr,
    output logic [7:0]                    code_wdata,
    output logic                          vm_start,
    output logic                          busy,
    output logic                          err,
    output logic [7:0]                    prog_len
);

    localparam int unsigned ADDR_W  = $clog2(CODE_DEPTH);
    localparam int unsigned DIV     = calc_div(FREQ, BAUD);
    localparam int unsigned TMO_CYC = calc_timeout(FREQ, BAUD, TIMEOUT_BITS);
    localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    frame_state_e      state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              code_we_q, code_we_d;
    logic [ADDR_W-1:0] code_addr_q, code_addr_d;
    logic [7:0]        code_wdata_q, code_wdata_d;
    logic              vm_start_q, vm_start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [7:0]        prog_len_q, prog_len_d;
    logic              tmo_hit;
    logic              len_bad;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst),
        .rx_i       (uart_rxp),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .rx_ferr_o  (rx_ferr)
    );

    assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC));
    assign len_bad = (rx_data == 8'd0) || ({1'b0, rx_data} > 9'(CODE_DEPTH));

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            code_we_q    <= 1'b0;
            code_addr_q  <= '0;
            code_wdata_q <= '0;
            vm_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            prog_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            code_we_q    <= code_we_d;
            code_addr_q  <= code_addr_d;
            code_wdata_q <= code_wdata_d;
            vm_start_q   <= vm_start_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            prog_len_q   <= prog_len_d;
        end
    end

    // Frame parser: SYNC, LEN, LEN payload bytes, CHK.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        code_we_d    = 1'b0;
        code_addr_d  = code_addr_q;
        code_wdata_d = code_wdata_q;
        vm_start_d   = 1'b0;
        busy_d       = busy_q;
        err_d        = err_q;
        prog_len_d   = prog_len_q;

        // Inter-byte watchdog, only running inside a frame.
        if (state_q == ST_IDLE || rx_valid) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (state_q != ST_IDLE && (rx_ferr || tmo_hit)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ST_LEN;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                ST_LEN: begin
                    if (len_bad) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                        len_d   = rx_data;
                        idx_d   = '0;
                        sum_d   = '0;
                    end
                end
                ST_DATA: begin
                    // SYNC values here are payload, never a resync.
                    code_we_d    = 1'b1;
                    code_addr_d  = ADDR_W'(idx_q);
                    code_wdata_d = rx_data;
                    sum_d        = sum_q + rx_data;
                    idx_d        = idx_q + 8'd1;
                    if (idx_d == len_q) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (rx_data == sum_q) begin
                        vm_start_d = 1'b1;
                        prog_len_d = len_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign code_we    = code_we_q;
    assign code_addr  = code_addr_q;
    assign code_wdata = code_wdata_q;
    assign vm_start   = vm_start_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int unsigned DIV      = 16;
    localparam int unsigned TMO_BITS = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxp;
    logic       code_we;
    logic [3:0] code_addr;
    logic [7:0] code_wdata;
    logic       vm_start;
    logic       busy;
    logic       err;
    logic [7:0] prog_len;

    int checks   = 0;
    int errors   = 0;
    int vm_count = 0;
    int exp_vm   = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  pl[$];

    prog_loader #(
        .FREQ         (1600),
        .BAUD         (100),
        .CODE_DEPTH   (16),
        .TIMEOUT_BITS (TMO_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxp   (uart_rxp),
        .code_we    (code_we),
        .code_addr  (code_addr),
        .code_wdata (code_wdata),
        .vm_start   (vm_start),
        .busy       (busy),
        .err        (err),
        .prog_len   (prog_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rxp = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxp = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxp = stop;
        repeat (DIV) @(negedge clk);
        uart_rxp = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    // Sends pl[first..last-1] as payload, queuing the expected writes first.
    task automatic send_payload(input int first, input int last);
        for (int i = first; i < last; i++) begin
            exp_q.push_back({4'(i), pl[i]});
            send_byte(pl[i], 1'b1);
        end
    endtask

    function automatic logic [7:0] pl_sum();
        logic [7:0] s = 8'd0;
        foreach (pl[i]) s = s + pl[i];
        return s;
    endfunction

    task automatic send_frame(input logic [7:0] chk);
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'(pl.size()), 1'b1);
        send_payload(0, pl.size());
        send_byte(chk, 1'b1);
        if (chk == pl_sum()) exp_vm++;
        repeat (4) @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on each write, counts starts.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (code_we === 1'b1) begin
                check("we_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("we_addr", 32'(code_addr), 32'(e[11:8]));
                    check("we_data", 32'(code_wdata), 32'(e[7:0]));
                end
            end
            if (vm_start === 1'b1) begin
                vm_count++;
                check("vm_we_overlap", 32'(code_we), 32'd0);
                check("vm_pending_writes", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    initial begin
        rst      = 1'b0;
        uart_rxp = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_code_we", 32'(code_we), 32'd0);
        check("rst_code_addr", 32'(code_addr), 32'd0);
        check("rst_code_wdata", 32'(code_wdata), 32'd0);
        check("rst_vm_start", 32'(vm_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        rst = 1'b1;
        repeat (4 * DIV) @(negedge clk);

        // Garbage before SYNC, then the reference program.
        send_byte(8'hA3, 1'b1);
        check("garbage_busy", 32'(busy), 32'd0);
        check("garbage_err", 32'(err), 32'd0);
        pl = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
               8'h04, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00};
        send_byte(SYNC_BYTE, 1'b1);
        check("good_busy_after_sync", 32'(busy), 32'd1);
        send_byte(8'd13, 1'b1);
        send_payload(0, 13);
        send_byte(8'h0F, 1'b1);
        exp_vm++;
        repeat (4) @(negedge clk);
        check("good_vm_count", 32'(vm_count), 32'(exp_vm));
        check("good_prog_len", 32'(prog_len), 32'd13);
        check("good_err", 32'(err), 32'd0);
        check("good_busy_end", 32'(busy), 32'd0);
        check("good_writes_done", 32'(exp_q.size()), 32'd0);

        // Same frame, wrong checksum.
        send_frame(8'h10);
        check("badchk_vm_count", 32'(vm_count), 32'(exp_vm));
        check("badchk_err", 32'(err), 32'd1);
        check("badchk_prog_len", 32'(prog_len), 32'd13);
        check("badchk_writes_done", 32'(exp_q.size()), 32'd0);

        // Following good frame clears err on SYNC.
        pl = '{8'h10, 8'h20, 8'h30};
        send_byte(SYNC_BYTE, 1'b1);
        check("sync_clears_err", 32'(err), 32'd0);
        send_byte(8'd3, 1'b1);
        send_payload(0, 3);
        send_byte(8'h60, 1'b1);
        exp_vm++;
        repeat (4) @(negedge clk);
        check("short_vm_count", 32'(vm_count), 32'(exp_vm));
        check("short_prog_len", 32'(prog_len), 32'd3);

        // Quarter-bit glitch on an idle line.
        @(negedge clk);
        uart_rxp = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        uart_rxp = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_idle_err", 32'(err), 32'd0);
        check("glitch_idle_busy", 32'(busy), 32'd0);

        // Glitch inside DATA must not inject a byte; 0x55 in payload is data.
        pl = '{8'h5A, 8'h55, 8'hC3, 8'h01};
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd4, 1'b1);
        send_payload(0, 1);
        @(negedge clk);
        uart_rxp = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        uart_rxp = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        send_payload(1, 4);
        send_byte(pl_sum(), 1'b1);
        exp_vm++;
        repeat (4) @(negedge clk);
        check("glitch_data_vm_count", 32'(vm_count), 32'(exp_vm));
        check("glitch_data_prog_len", 32'(prog_len), 32'd4);
        check("glitch_data_err", 32'(err), 32'd0);

        // Illegal lengths.
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'h00, 1'b1);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        send_byte(SYNC_BYTE, 1'b1);
        check("len17_sync_err", 32'(err), 32'd0);
        send_byte(8'h11, 1'b1);
        check("len17_err", 32'(err), 32'd1);
        check("len17_busy", 32'(busy), 32'd0);
        send_byte(8'h00, 1'b1);
        check("idle_zero_busy", 32'(busy), 32'd0);
        check("idle_zero_err", 32'(err), 32'd1);
        check("badlen_prog_len", 32'(prog_len), 32'd4);

        // Framing error in DATA, then ignored bytes until SYNC.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd5, 1'b1);
        send_payload(0, 2);
        send_byte(8'h33, 1'b0);
        check("ferr_err", 32'(err), 32'd1);
        check("ferr_busy", 32'(busy), 32'd0);
        send_byte(8'h44, 1'b1);
        send_byte(8'h66, 1'b1);
        check("ferr_ignored_busy", 32'(busy), 32'd0);
        check("ferr_ignored_writes", 32'(exp_q.size()), 32'd0);
        pl = '{8'h7E};
        send_frame(8'h7E);
        check("recover_vm_count", 32'(vm_count), 32'(exp_vm));
        check("recover_prog_len", 32'(prog_len), 32'd1);
        check("recover_err", 32'(err), 32'd0);

        // Inter-byte timeout after 5 of 13 payload bytes.
        pl = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
               8'h04, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00};
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd13, 1'b1);
        send_payload(0, 5);
        check("tmo_busy_start", 32'(busy), 32'd1);
        repeat (10 * DIV) @(negedge clk);
        check("tmo_not_yet_err", 32'(err), 32'd0);
        check("tmo_not_yet_busy", 32'(busy), 32'd1);
        repeat ((TMO_BITS - 10) * DIV + 4 * DIV) @(negedge clk);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("tmo_vm_count", 32'(vm_count), 32'(exp_vm));

        // Asynchronous reset in the middle of a frame.
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd13, 1'b1);
        send_payload(0, 3);
        @(negedge clk);
        uart_rxp = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_prog_len", 32'(prog_len), 32'd0);
        check("arst_code_we", 32'(code_we), 32'd0);
        check("arst_code_wdata", 32'(code_wdata), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
        uart_rxp = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (30 * DIV) @(negedge clk);
        check("arst_vm_count", 32'(vm_count), 32'(exp_vm));
        check("arst_busy_after", 32'(busy), 32'd0);
        check("arst_err_after", 32'(err), 32'd0);
        check("final_writes_done", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
